// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command/response and APB signal bundle for apb_master_bridge
interface apb_master_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    // master is the bridge; slave is the requester plus APB completer side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, paddr, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, paddr, pwrite, pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-beat command to APB SETUP/ACCESS initiator with wait-state watchdog
module apb_master_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_bridge_if.master bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             done;
    logic             abort;

    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.psel      = (state == SETUP) || (state == ACCESS);
    assign bus.penable   = (state == ACCESS);

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt == LAST_WAIT)) begin
                    // this wait cycle is the TIMEOUT-th one without pready
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            bus.paddr     <= '0;
            bus.pwrite    <= 1'b0;
            bus.pwdata    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.rsp_valid <= done || abort;
            if (accept) begin
                bus.paddr  <= bus.cmd_addr;
                bus.pwrite <= bus.cmd_write;
                bus.pwdata <= bus.cmd_wdata;
                wait_cnt   <= '0;
            end
            if ((state == ACCESS) && !bus.pready && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (done) begin
                bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
                bus.rsp_err   <= 1'b0;
            end
            if (abort) begin
                bus.rsp_rdata <= '0;
                bus.rsp_err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized bench for apb_master_bridge with memory-backed completer
module tb_apb_master_bridge;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int total = 0;
    int bad   = 0;

    // ref_mem is the transaction-level expectation; comp_mem is what the completer stores from the pins
    logic [DW-1:0] ref_mem  [0:4095];
    logic [DW-1:0] comp_mem [0:4095];
    logic [DW-1:0] last_rd  = '0;
    logic          last_err = 1'b0;
    logic [AW-1:0] pool [8] = '{12'h000, 12'h004, 12'hFF4, 12'hFFC, 12'h010, 12'h800, 12'h7FC, 12'hFF8};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_cmd();
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = $urandom;
    endtask

    task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input logic busy_valid);
        int            n_access;
        int            guard;
        bit            aborts;
        logic [DW-1:0] exp_rd;
        aborts   = (TO != 0) && (waits >= TO);
        n_access = aborts ? TO : waits + 1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_ready", 64'(bus.cmd_ready), 64'(1));
        @(negedge clk);
        check_eq("setup_psel", 64'(bus.psel), 64'(1));
        check_eq("setup_penable", 64'(bus.penable), 64'(0));
        check_eq("setup_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        check_eq("setup_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("setup_paddr", 64'(bus.paddr), 64'(a));
        check_eq("setup_pwrite", 64'(bus.pwrite), 64'(w));
        check_eq("setup_pwdata", 64'(bus.pwdata), 64'(d));
        bus.cmd_valid = busy_valid;
        scramble_cmd();
        bus.pready = 1'($urandom);
        bus.prdata = $urandom;
        for (int k = 0; k < n_access; k++) begin
            @(negedge clk);
            check_eq("access_psel", 64'(bus.psel), 64'(1));
            check_eq("access_penable", 64'(bus.penable), 64'(1));
            check_eq("access_paddr", 64'(bus.paddr), 64'(a));
            check_eq("access_pwrite", 64'(bus.pwrite), 64'(w));
            check_eq("access_pwdata", 64'(bus.pwdata), 64'(d));
            check_eq("access_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check_eq("access_cmd_ready", 64'(bus.cmd_ready), 64'(0));
            scramble_cmd();
            if (!aborts && k == waits) begin
                bus.pready = 1'b1;
                if (bus.pwrite) begin
                    comp_mem[bus.paddr] = bus.pwdata;
                    bus.prdata = $urandom;
                end else begin
                    bus.prdata = comp_mem[bus.paddr];
                end
            end else begin
                bus.pready = 1'b0;
                bus.prdata = $urandom;
            end
        end
        @(negedge clk);
        exp_rd = (aborts || w) ? '0 : ref_mem[a];
        if (!aborts && w) ref_mem[a] = d;
        check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check_eq("rsp_err", 64'(bus.rsp_err), 64'(aborts));
        check_eq("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        check_eq("rsp_psel", 64'(bus.psel), 64'(0));
        check_eq("rsp_penable", 64'(bus.penable), 64'(0));
        check_eq("rsp_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        last_rd  = exp_rd;
        last_err = aborts;
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'($urandom);
    endtask

    task automatic idle_cycle();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("idle_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("idle_psel", 64'(bus.psel), 64'(0));
        check_eq("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check_eq("hold_rsp_rdata", 64'(bus.rsp_rdata), 64'(last_rd));
        check_eq("hold_rsp_err", 64'(bus.rsp_err), 64'(last_err));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i]  = '0;
            comp_mem[i] = '0;
        end
        bus.cmd_valid  = 1'b0;
        bus.cmd_write  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.pready     = 1'b1;
        bus.prdata     = '0;
        bus0.cmd_valid = 1'b0;
        bus0.cmd_write = 1'b0;
        bus0.cmd_addr  = '0;
        bus0.cmd_wdata = '0;
        bus0.pready    = 1'b0;
        bus0.prdata    = '0;

        bus.cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_psel", 64'(bus.psel), 64'(0));
        check_eq("reset_penable", 64'(bus.penable), 64'(0));
        check_eq("reset_paddr", 64'(bus.paddr), 64'(0));
        check_eq("reset_pwrite", 64'(bus.pwrite), 64'(0));
        check_eq("reset_pwdata", 64'(bus.pwdata), 64'(0));
        check_eq("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check_eq("reset_rsp_err", 64'(bus.rsp_err), 64'(0));
        check_eq("reset_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        idle_cycle();

        run_cmd(1'b1, 12'hFF4, 32'hFFFF_FF01, 0, 1'b0);
        idle_cycle();
        run_cmd(1'b1, 12'hFF4, 32'hA5A5_5A5A, 1, 1'b0);
        idle_cycle();
        run_cmd(1'b0, 12'hFF4, 32'h0, 2, 1'b0);
        check_eq("read_wait2_data", 64'(bus.rsp_rdata), 64'(32'hA5A5_5A5A));
        idle_cycle();
        run_cmd(1'b0, 12'hFF4, 32'h0, 50, 1'b1);
        idle_cycle();

        run_cmd(1'b1, 12'h010, 32'h1111_2222, 0, 1'b1);
        run_cmd(1'b0, 12'h010, 32'h0, 1, 1'b1);
        run_cmd(1'b1, 12'h014, 32'h3333_4444, 3, 1'b1);
        idle_cycle();

        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 12'hFF4;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        @(negedge clk);
        check_eq("kill_access_penable", 64'(bus.penable), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check_eq("kill_psel", 64'(bus.psel), 64'(0));
        check_eq("kill_penable", 64'(bus.penable), 64'(0));
        check_eq("kill_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check_eq("kill_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        rst = 1'b0;
        bus.pready = 1'b1;
        last_rd  = '0;
        last_err = 1'b0;
        idle_cycle();
        run_cmd(1'b1, 12'hFF4, 32'h1234_5678, 0, 1'b0);
        idle_cycle();
        run_cmd(1'b0, 12'hFF4, 32'h0, 0, 1'b0);
        check_eq("sram_readback", 64'(bus.rsp_rdata), 64'(32'h1234_5678));
        idle_cycle();

        for (int n = 0; n < 150; n++) begin
            run_cmd(1'($urandom), pool[$urandom_range(0, 7)], $urandom,
                    int'($urandom_range(0, 6)), 1'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 2)) idle_cycle();
            end
        end
        idle_cycle();

        bus0.cmd_valid = 1'b1;
        bus0.cmd_write = 1'b0;
        bus0.cmd_addr  = 12'hFF4;
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 101; k++) begin
            @(negedge clk);
            if (bus0.rsp_valid === 1'b1) seen++;
        end
        check_eq("nto_no_rsp", 64'(seen), 64'(0));
        check_eq("nto_psel", 64'(bus0.psel), 64'(1));
        check_eq("nto_penable", 64'(bus0.penable), 64'(1));
        bus0.pready = 1'b1;
        bus0.prdata = 32'hA5A5_5A5A;
        @(negedge clk);
        bus0.pready = 1'b0;
        check_eq("nto_rsp_valid", 64'(bus0.rsp_valid), 64'(1));
        check_eq("nto_rsp_err", 64'(bus0.rsp_err), 64'(0));
        check_eq("nto_rsp_rdata", 64'(bus0.rsp_rdata), 64'(32'hA5A5_5A5A));
        @(negedge clk);
        check_eq("nto_rsp_pulse", 64'(bus0.rsp_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
